time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Upstream timekeeping stage for the clock display: produces the six 4-bit BCD digits (HH:MM:SS, 24 h) that drive the `number` input of each per-digit font/colour lookup stage.
- Contains a 1 Hz prescaler, a BCD carry chain and three button-adjust paths (hours, minutes, seconds), each with synchroniser, debounce, edge detect and auto-repeat.
- Outputs are registered and stable for whole seconds, so the pixel pipeline can sample them at any time.

Parameters:
- CLK_HZ, 31_500_000, pixel clock frequency; prescaler period in cycles.
- DEBOUNCE_CYCLES, 65_536, consecutive stable synchronised samples needed to accept a button level change.
- REPEAT_CYCLES, 15_750_000, while a debounced button stays high, one extra increment every REPEAT_CYCLES cycles.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- adj_hrs  in  1  raw async button, increments hours
- adj_min  in  1  raw async button, increments minutes
- adj_sec  in  1  raw async button, clears seconds and realigns prescaler
- hrs_d  out  4  hours tens BCD, 0-2
- hrs_u  out  4  hours units BCD, 0-9 (0-3 when hrs_d=2)
- min_d  out  4  minutes tens BCD, 0-5
- min_u  out  4  minutes units BCD, 0-9
- sec_d  out  4  seconds tens BCD, 0-5
- sec_u  out  4  seconds units BCD, 0-9
- tick_1hz  out  1  one-cycle pulse in the cycle after the seconds update

Behaviour:
- Reset (sync, active-high):
  - all digit outputs 0, tick_1hz 0, prescaler 0.
  - synchroniser and debounce state 0; repeat counters 0.
  - Reset mid-operation overrides everything in that cycle.
- Prescaler:
  - counts 0..CLK_HZ-1 and wraps to 0.
  - Internal tick is asserted combinationally when the count equals CLK_HZ-1.
  - On that clock edge the seconds increment and the prescaler wraps; tick_1hz is high the following cycle.
- Carry chain, all in one cycle:
  - sec_u 9→0 carries into sec_d; sec_d 5 (with carry) →0 carries into minutes.
  - min_u/min_d follow the same pattern and carry into hours.
  - Hours wrap 23→00, i.e. hrs_d=2 and hrs_u=3 → 0,0.
  - 23:59:59 + tick → 00:00:00.
  - Illegal BCD codes are never produced.
- Button path, each button independent:
  - 2-FF synchroniser, then debounce counter.
  - The counter resets whenever the sync sample equals the current debounced level.
  - When the count reaches DEBOUNCE_CYCLES-1 with a differing sample, the debounced level toggles.
  - Rising edge of the debounced level produces one adjust pulse.
  - Latency: raw rise held stable → adjust visible on outputs exactly DEBOUNCE_CYCLES+3 cycles later.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Auto-repeat:
  - While the debounced level is high, the repeat counter counts.
  - Each time it reaches REPEAT_CYCLES-1 it wraps and emits another adjust pulse.
  - Cleared when the level goes low.
- Adjust effects:
  - adj_hrs: hours +1 mod 24; minutes and seconds unchanged.
  - adj_min: minutes +1 mod 60; no carry into hours.
  - adj_sec: seconds ← 00, prescaler ← 0; no tick generated that cycle.
- Simultaneous events:
  - Adjust has priority for its own field. A carry from the tick into an adjusted field in the same cycle is dropped; that field advances by exactly 1.
  - Lower fields still take the tick (e.g. 12:34:59 + tick + adj_min → 12:35:00).
  - Tick coinciding with adj_sec: seconds ← 00 and no carry to minutes.
  - Multiple buttons in the same cycle: each applies to its own field.

Decomposition:
- Shared package: BCD digit width (4), per-field max constants (SEC_D_MAX=5, MIN_D_MAX=5, HRS_D_MAX=2, HRS_U_MAX_AT_2=3), BCD digit type.
- Sub-module: button_debounce (sync + debounce + edge + auto-repeat, parameters DEBOUNCE_CYCLES/REPEAT_CYCLES, output adjust pulse), instantiated three times.
- BCD increment kept as a function in the package.

Test Plan:
Bench parameters: CLK_HZ=10, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
- Reset, run 25 cycles → at cycle 10 outputs 00:00:01, at cycle 20 00:00:02; tick_1hz high for exactly one cycle after each update.
- Preload 23:59:58 via adjusts, run 2 ticks → 23:59:59 then 00:00:00, all six digits in the same cycle.
- Raise adj_min stable at cycle t, time 12:34:20 → min 35 appears at t+7; hold 40 more cycles → 36, 37 at 20-cycle intervals; release → no further change.
- Pulse adj_hrs high for 3 cycles → no change; hours 23 + valid press → 00, minutes/seconds untouched.
- At 12:34:59 align adj_min pulse with tick → 12:35:00, not 12:36:00; align adj_sec with tick at 12:34:59 → 12:34:00, prescaler restarts at 0.
- Assert reset mid-second at 05:06:07 → next cycle all zeros, tick_1hz 0, first tick exactly CLK_HZ cycles after reset deasserts.

Source files
------------

// File: rtl/time_counter_pkg.sv
// Shared definitions for the HH:MM:SS timekeeping block.
// Contents: BCD digit type, per-field digit limits, two-digit BCD increment helper.
// No ports; pure types, constants and a combinational function.
package time_counter_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   // Field limits in BCD. Units always roll at 9 except hours units when tens is 2.
   localparam bcd_t SEC_D_MAX      = 4'd5;
   localparam bcd_t MIN_D_MAX      = 4'd5;
   localparam bcd_t HRS_D_MAX      = 4'd2;
   localparam bcd_t HRS_U_MAX_AT_2 = 4'd3;
   localparam bcd_t UNITS_MAX      = 4'd9;

   typedef struct packed {
      bcd_t tens;
      bcd_t units;
   } bcd_pair_t;

   typedef struct packed {
      logic      carry;
      bcd_pair_t val;
   } bcd_inc_t;

   // Increment a two-digit BCD field. The field wraps to 00 (with carry out)
   // when it sits at {tens_max, units_last}; otherwise units roll 9 -> 0 into tens.
   function automatic bcd_inc_t bcd_pair_inc(input bcd_pair_t v,
                                             input bcd_t      tens_max,
                                             input bcd_t      units_last);
      bcd_inc_t r;
      r.carry = 1'b0;
      r.val   = v;
      if ((v.tens == tens_max) && (v.units == units_last)) begin
         r.val   = '0;
         r.carry = 1'b1;
      end else if (v.units >= UNITS_MAX) begin
         r.val.tens  = v.tens + 1'b1;
         r.val.units = '0;
      end else begin
         r.val.units = v.units + 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/time_counter_button_debounce.sv
// Button conditioner: 2-FF sync, debounce, rising-edge pulse, auto-repeat while held.
// Ports: clk, reset (sync, active-high), btn_raw (async) -> adj_pulse (1-cycle pulse).
// Latency: raw edge to pulse DEBOUNCE_CYCLES+2 cycles; no backpressure, pulses are fire-and-forget.
module button_debounce
   import time_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65_536,
   parameter int REPEAT_CYCLES   = 15_750_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic adj_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          level_prev_q, level_prev_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rise;
   logic          rep_fire;

   always_comb begin
      sync1_d      = btn_raw;
      sync2_d      = sync1_q;
      level_d      = level_q;
      db_cnt_d     = db_cnt_q;
      level_prev_d = level_q;

      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2_q == level_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         level_d  = ~level_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end

      rise     = level_q & ~level_prev_q;
      rep_fire = level_q & ~rise & (rep_cnt_q == REP_LAST);

      // The press pulse restarts the repeat interval so every repeat is a full period apart.
      if (!level_q || rise || rep_fire) begin
         rep_cnt_d = '0;
      end else begin
         rep_cnt_d = rep_cnt_q + 1'b1;
      end

      adj_pulse = rise | rep_fire;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         db_cnt_q     <= '0;
         rep_cnt_q    <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
         db_cnt_q     <= db_cnt_d;
         rep_cnt_q    <= rep_cnt_d;
      end
   end

endmodule

// File: rtl/time_counter.sv
// 24 h BCD clock: 1 Hz prescaler, seconds/minutes/hours carry chain, three adjust buttons.
// Ports: clk, reset (sync, active-high), adj_hrs/adj_min/adj_sec (raw async) -> six BCD digits + tick_1hz.
// Latency: digits registered, update on the prescaler wrap or an adjust pulse; no backpressure.
module time_counter
   import time_counter_pkg::*;
#(
   parameter int CLK_HZ          = 31_500_000,
   parameter int DEBOUNCE_CYCLES = 65_536,
   parameter int REPEAT_CYCLES   = 15_750_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adj_hrs,
   input  logic       adj_min,
   input  logic       adj_sec,
   output logic [3:0] hrs_d,
   output logic [3:0] hrs_u,
   output logic [3:0] min_d,
   output logic [3:0] min_u,
   output logic [3:0] sec_d,
   output logic [3:0] sec_u,
   output logic       tick_1hz
);

   localparam int PW = $clog2(CLK_HZ + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] presc_q, presc_d;
   bcd_pair_t     seconds_q, seconds_d;
   bcd_pair_t     minutes_q, minutes_d;
   bcd_pair_t     hours_q, hours_d;
   logic          tick_1hz_q, tick_1hz_d;

   logic          adj_hrs_p, adj_min_p, adj_sec_p;
   logic          tick;
   logic          sec_carry, min_carry;
   bcd_inc_t      sec_inc, min_inc, hrs_inc;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_hrs (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (adj_hrs),
      .adj_pulse (adj_hrs_p)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_min (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (adj_min),
      .adj_pulse (adj_min_p)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_sec (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (adj_sec),
      .adj_pulse (adj_sec_p)
   );

   always_comb begin
      tick = (presc_q == PRESC_LAST);

      // adj_sec realigns the second boundary: prescaler restarts and the tick is swallowed.
      presc_d    = (tick || adj_sec_p) ? '0 : presc_q + 1'b1;
      tick_1hz_d = tick & ~adj_sec_p;

      sec_inc = bcd_pair_inc(seconds_q, SEC_D_MAX, UNITS_MAX);
      min_inc = bcd_pair_inc(minutes_q, MIN_D_MAX, UNITS_MAX);
      hrs_inc = bcd_pair_inc(hours_q, HRS_D_MAX, HRS_U_MAX_AT_2);

      seconds_d = seconds_q;
      sec_carry = 1'b0;
      if (adj_sec_p) begin
         seconds_d = '0;
      end else if (tick) begin
         seconds_d = sec_inc.val;
         sec_carry = sec_inc.carry;
      end

      // An adjusted field advances by exactly one; a coincident carry into it is dropped
      // and does not propagate further up.
      minutes_d = minutes_q;
      min_carry = 1'b0;
      if (adj_min_p) begin
         minutes_d = min_inc.val;
      end else if (sec_carry) begin
         minutes_d = min_inc.val;
         min_carry = min_inc.carry;
      end

      hours_d = hours_q;
      if (adj_hrs_p || min_carry) begin
         hours_d = hrs_inc.val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q    <= '0;
         seconds_q  <= '0;
         minutes_q  <= '0;
         hours_q    <= '0;
         tick_1hz_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         seconds_q  <= seconds_d;
         minutes_q  <= minutes_d;
         hours_q    <= hours_d;
         tick_1hz_q <= tick_1hz_d;
      end
   end

   assign hrs_d    = hours_q.tens;
   assign hrs_u    = hours_q.units;
   assign min_d    = minutes_q.tens;
   assign min_u    = minutes_q.units;
   assign sec_d    = seconds_q.tens;
   assign sec_u    = seconds_q.units;
   assign tick_1hz = tick_1hz_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter with small timing parameters.
// A time-of-day model (plain integers) predicts every cycle; a negedge monitor compares.
module tb_time_counter;

   localparam int CLK_HZ = 10;
   localparam int DEB    = 4;
   localparam int REP    = 20;

   localparam logic [24:0] M_ALL = 25'h1FF_FFFF;
   localparam logic [24:0] M_HM  = 25'h1FF_FE00;
   localparam logic [24:0] M_MIN = 25'h001_FE00;

   logic       clk;
   logic       reset;
   logic       adj_hrs, adj_min, adj_sec;
   logic [3:0] hrs_d, hrs_u, min_d, min_u, sec_d, sec_u;
   logic       tick_1hz;

   time_counter #(
      .CLK_HZ          (CLK_HZ),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .adj_hrs  (adj_hrs),
      .adj_min  (adj_min),
      .adj_sec  (adj_sec),
      .hrs_d    (hrs_d),
      .hrs_u    (hrs_u),
      .min_d    (min_d),
      .min_u    (min_u),
      .sec_d    (sec_d),
      .sec_u    (sec_u),
      .tick_1hz (tick_1hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Reference state: time of day as integers, prescaler phase, tick output.
   int m_h = 0, m_m = 0, m_s = 0, m_p = 0;
   bit m_tick = 1'b0;

   logic [24:0] exp_q[$];
   int pq_h[$], pq_m[$], pq_s[$];

   function automatic logic [24:0] mk(input int h, input int m, input int s, input bit t);
      logic [3:0] a, b, c, d, e, f;
      a = 4'(h / 10); b = 4'(h % 10);
      c = 4'(m / 10); d = 4'(m % 10);
      e = 4'(s / 10); f = 4'(s % 10);
      return {a, b, c, d, e, f, t};
   endfunction

   function logic [24:0] dut_vec();
      return {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, tick_1hz};
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int r;
      r = a;
      if (b > r) r = b;
      if (c > r) r = c;
      return r;
   endfunction

   // Hold length giving exactly n increments: first at the press, then one per REP cycles.
   function automatic int hold_for(input int n);
      if (n == 0) return 0;
      if (n == 1) return DEB;
      return REP * (n - 1) + 1;
   endfunction

   // One clock edge: advance the model with the inputs present at this edge.
   task automatic step();
      bit ph, pm, ps, tk, cs, cm;
      @(posedge clk);
      edge_n++;
      ph = (pq_h.size() > 0) && (pq_h[0] == edge_n);
      pm = (pq_m.size() > 0) && (pq_m[0] == edge_n);
      ps = (pq_s.size() > 0) && (pq_s[0] == edge_n);
      if (ph) void'(pq_h.pop_front());
      if (pm) void'(pq_m.pop_front());
      if (ps) void'(pq_s.pop_front());
      if (reset) begin
         m_h = 0; m_m = 0; m_s = 0; m_p = 0; m_tick = 1'b0;
      end else begin
         tk     = (m_p == CLK_HZ - 1);
         m_tick = tk && !ps;
         m_p    = (tk || ps) ? 0 : m_p + 1;
         cs = 1'b0;
         if (ps) m_s = 0;
         else if (tk) begin
            cs  = (m_s == 59);
            m_s = (m_s + 1) % 60;
         end
         cm = 1'b0;
         if (pm) m_m = (m_m + 1) % 60;
         else if (cs) begin
            cm  = (m_m == 59);
            m_m = (m_m + 1) % 60;
         end
         if (ph || cm) m_h = (m_h + 1) % 24;
      end
      exp_q.push_back(mk(m_h, m_m, m_s, m_tick));
      #1;
   endtask

   // Hold each button for its length (0 = untouched), then idle long enough to settle.
   // A press accepted at first sampling edge s yields increments at s+DEB+2+REP*k for REP*k < len.
   task automatic press(input int lh, input int lm, input int ls);
      int s, n;
      s = edge_n + 1;
      if (lh >= DEB) for (int k = 0; REP * k < lh; k++) pq_h.push_back(s + DEB + 2 + REP * k);
      if (lm >= DEB) for (int k = 0; REP * k < lm; k++) pq_m.push_back(s + DEB + 2 + REP * k);
      if (ls >= DEB) for (int k = 0; REP * k < ls; k++) pq_s.push_back(s + DEB + 2 + REP * k);
      n = max3(lh, lm, ls);
      for (int i = 0; i < n; i++) begin
         adj_hrs = (i < lh);
         adj_min = (i < lm);
         adj_sec = (i < ls);
         step();
      end
      adj_hrs = 1'b0;
      adj_min = 1'b0;
      adj_sec = 1'b0;
      repeat (12) step();
   endtask

   // Drive the model (and the DUT with it) to h:m:s using the buttons; seconds are held
   // at zero via adj_sec while hours/minutes are adjusted so no carry interferes.
   task automatic set_time(input int h, input int m, input int s);
      int lh, lm;
      press(0, 0, DEB);
      for (int it = 0; it < 3 && !(m_h == h && m_m == m); it++) begin
         lh = hold_for((h - m_h + 24) % 24);
         lm = hold_for((m - m_m + 60) % 60);
         press(lh, lm, max3(lh, lm, DEB));
      end
      for (int i = 0; i < 700 && m_s != s; i++) step();
   endtask

   // Position so that a press started now lands its pulse on a seconds tick at :59.
   task automatic wait_align(input bit need_min59);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (m_s == 59 && m_p == 3 && (!need_min59 || m_m == 59)) ok = 1'b1;
         else step();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL align_timeout got no alignment within 2000 cycles, required alignment");
      end
   endtask

   task automatic check_now(input string name, input logic [24:0] want, input logic [24:0] mask);
      logic [24:0] got;
      @(negedge clk);
      got = dut_vec();
      checks++;
      if ((got & mask) !== (want & mask)) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got & mask, want & mask);
      end
   endtask

   // Monitor: every cycle the DUT presents its digits; pop the prediction and compare.
   always @(negedge clk) begin
      logic [24:0] want, got;
      if (exp_q.size() != 0) begin
         want = exp_q.pop_front();
         got  = dut_vec();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL scoreboard t=%0t got %h required %h", $time, got, want);
         end
      end
   end

   initial begin
      int lh, lm, ls;
      reset   = 1'b1;
      adj_hrs = 1'b0;
      adj_min = 1'b0;
      adj_sec = 1'b0;
      step();
      step();
      check_now("reset_state", mk(0, 0, 0, 0), M_ALL);
      reset = 1'b0;

      // Free-running seconds.
      repeat (9) step();
      check_now("before_first_tick", mk(0, 0, 0, 0), M_ALL);
      step();
      check_now("first_tick", mk(0, 0, 1, 1), M_ALL);
      step();
      check_now("tick_one_cycle", mk(0, 0, 1, 0), M_ALL);
      repeat (9) step();
      check_now("second_tick", mk(0, 0, 2, 1), M_ALL);

      // Held minutes button: press plus two repeats, nothing after release.
      set_time(12, 34, 20);
      press(0, 47, 0);
      check_now("min_hold_repeat", mk(0, 37, 0, 0), M_MIN);
      repeat (20) step();
      check_now("min_after_release", mk(0, 37, 0, 0), M_MIN);

      // Glitch ignored, valid press wraps 23 -> 00 leaving minutes alone.
      set_time(23, 10, 5);
      press(3, 0, 0);
      check_now("hrs_glitch", mk(23, 10, 0, 0), M_HM);
      press(DEB, 0, 0);
      check_now("hrs_wrap", mk(0, 10, 0, 0), M_HM);

      // adj_min coinciding with the :59 tick.
      set_time(12, 34, 50);
      wait_align(1'b0);
      press(0, DEB, 0);
      check_now("min_vs_tick", mk(12, 35, 0, 0), M_ALL);

      // adj_sec coinciding with the :59 tick; prescaler restarts.
      set_time(12, 34, 50);
      wait_align(1'b0);
      press(0, 0, DEB);
      check_now("sec_vs_tick", mk(12, 34, 0, 0), M_ALL);
      step();
      check_now("sec_realign", mk(12, 34, 1, 1), M_ALL);

      // adj_hrs coinciding with the carry out of minutes.
      set_time(22, 59, 50);
      wait_align(1'b1);
      press(DEB, 0, 0);
      check_now("hrs_vs_carry", mk(23, 0, 0, 0), M_ALL);

      // Full-day rollover.
      set_time(23, 59, 58);
      repeat (10) step();
      check_now("to_235959", mk(23, 59, 59, 1), M_ALL);
      repeat (10) step();
      check_now("rollover", mk(0, 0, 0, 1), M_ALL);

      // Random presses, some simultaneous, some glitches, some with repeats.
      for (int r = 0; r < 24; r++) begin
         lh = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : 0;
         lm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : 0;
         ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
         if (lh == 0 && lm == 0 && ls == 0) lm = int'($urandom_range(1, 50));
         press(lh, lm, ls);
         repeat (int'($urandom_range(0, 15))) step();
      end

      // Reset mid-second.
      set_time(5, 6, 7);
      repeat (4) step();
      reset = 1'b1;
      step();
      check_now("reset_mid", mk(0, 0, 0, 0), M_ALL);
      reset = 1'b0;
      repeat (9) step();
      check_now("post_reset_no_tick", mk(0, 0, 0, 0), M_ALL);
      step();
      check_now("post_reset_tick", mk(0, 0, 1, 1), M_ALL);

      repeat (3) step();
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
